// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: FSM state encodings, requester IDs, latched command struct.
package mem_arb_pkg;

  // Arbiter FSM states (2-bit encoding)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Requester identifiers; also the bit index into the request vector
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // Access captured at grant time and held for the whole transaction
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: chooses one of two pending requests.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req[1:0] (bit0 core, bit1 DMA), last (ID granted last time),
//        gnt_id (chosen ID, meaningful when any=1), any (some request pending).
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  always_comb begin
    any = |req;
    if (req[PORT_CORE] && req[PORT_DMA]) begin
      // Tie: the requester that was not served last time wins
      gnt_id = ~last;
    end else begin
      // Sole requester (or none) wins regardless of history
      gnt_id = req[PORT_DMA] ? PORT_DMA : PORT_CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core and a DMA requester onto one fixed-latency memory port.
// Latency: request seen in IDLE at cycle N -> mem_en at N+1 -> ready at N+2+MEM_LAT.
// Backpressure: one access at a time; requests are only sampled in IDLE and
//   the loser simply stays pending until a later IDLE cycle.
// Ports: clk/reset (sync, active-high); core_* and dma_* requester ports
//   (req/we/addr/wdata in, ready pulse/rdata out); mem_* memory port; busy.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_ready,
  output logic [31:0] core_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  // WAIT runs while the counter counts MEM_LAT-1 down to 0
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        pick_id;
  logic        pick_any;
  mem_cmd_t    core_cmd;
  mem_cmd_t    dma_cmd;

  assign core_cmd = '{we: core_we, addr: core_addr, wdata: core_wdata};
  assign dma_cmd  = '{we: dma_we,  addr: dma_addr,  wdata: dma_wdata};

  rr_pick2 u_pick (
    .req    ({dma_req, core_req}),
    .last   (last_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_id;
          last_d  = pick_id;
          cmd_d   = (pick_id == PORT_DMA) ? dma_cmd : core_cmd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Captured on writes too; the requester ignores it then
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= PORT_CORE;
      // Pretend DMA was served last so the core wins the first tie
      last_q  <= PORT_DMA;
      cmd_q   <= '0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes only in ISSUE; address/data keep the latched command otherwise
  assign mem_en     = (state_q == ST_ISSUE);
  assign mem_we     = mem_en & cmd_q.we;
  assign mem_addr   = cmd_q.addr;
  assign mem_wdata  = cmd_q.wdata;

  assign core_ready = (state_q == ST_RESP) && (gnt_q == PORT_CORE);
  assign dma_ready  = (state_q == ST_RESP) && (gnt_q == PORT_DMA);
  assign core_rdata = rdata_q;
  assign dma_rdata  = rdata_q;

  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=4) share stimulus.
// Each scenario task drives inputs cycle by cycle and checks outputs on the
// falling edge; expected completions are queued when requests are driven.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;

  logic        core_ready1, dma_ready1, mem_en1, mem_we1, busy1;
  logic [31:0] core_rdata1, dma_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        core_ready4, dma_ready4, mem_en4, mem_we4, busy4;
  logic [31:0] core_rdata4, dma_rdata4, mem_addr4, mem_wdata4, mem_rdata4;

  mem_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ready(core_ready1), .core_rdata(core_rdata1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready1), .dma_rdata(dma_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_arbiter #(.MEM_LAT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ready(core_ready4), .core_rdata(core_rdata4),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready4), .dma_rdata(dma_rdata4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4)
  );

  // Memory contents as a pure function of address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: read data is valid only in the cycle exactly MEM_LAT
  // after the mem_en cycle, garbage otherwise.
  logic        act1 = 1'b0, act4 = 1'b0;
  int          age1 = 0, age4 = 0;
  logic [31:0] ra1 = '0, ra4 = '0;
  always @(negedge clk) begin
    if (mem_en1) begin act1 = 1'b1; age1 = 0; ra1 = mem_addr1; end
    else if (act1) age1++;
    mem_rdata1 = (act1 && age1 == 1) ? mem_val(ra1) : 32'hBAD0BAD0;
    if (mem_en4) begin act4 = 1'b1; age4 = 0; ra4 = mem_addr4; end
    else if (act4) age4++;
    mem_rdata4 = (act4 && age4 == 4) ? mem_val(ra4) : 32'hBAD0BAD0;
  end

  typedef struct {
    logic        id;
    logic        chk;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic push_exp(input logic id, input logic chk, input logic [31:0] rd, input int cyc);
    exp_t e;
    e.id = id; e.chk = chk; e.rdata = rd; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Leaves the bench at cycle 0: reset just released, inputs idle
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      vectors++;
      if ({busy1, mem_en1, mem_we1, core_ready1, dma_ready1} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset ctl1 t=%0d: got %b, want 00000", t, {busy1, mem_en1, mem_we1, core_ready1, dma_ready1});
      end
      vectors++;
      if ({mem_addr1, mem_wdata1, core_rdata1, dma_rdata1} !== 128'd0) begin
        miscompares++;
        $display("FAIL reset data1 t=%0d: got %h %h %h %h, want zeros", t, mem_addr1, mem_wdata1, core_rdata1, dma_rdata1);
      end
      vectors++;
      if ({busy4, mem_en4, mem_we4, core_ready4, dma_ready4} !== 5'b0 ||
          {mem_addr4, mem_wdata4, core_rdata4} !== 96'd0) begin
        miscompares++;
        $display("FAIL reset dut4 t=%0d: got busy=%b en=%b addr=%h rdata=%h, want zeros", t, busy4, mem_en4, mem_addr4, core_rdata4);
      end
    end
  endtask

  task automatic test_core_read();
    exp_t e;
    do_reset();
    for (int t = 1; t <= 11; t++) begin
      @(posedge clk); #1;
      if (t == 5) begin
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        push_exp(PORT_CORE, 1'b1, 32'hDEADBEEF, 8);
      end
      if (t == 9) core_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_en1 !== (t == 6) || mem_we1 !== 1'b0) begin
        miscompares++;
        $display("FAIL core_read mem_en t=%0d: got en=%b we=%b, want en=%b we=0", t, mem_en1, mem_we1, t == 6);
      end
      if (t == 6) begin
        vectors++;
        if (mem_addr1 !== 32'h10) begin
          miscompares++;
          $display("FAIL core_read mem_addr: got %h, want 00000010", mem_addr1);
        end
      end
      vectors++;
      if (core_ready1 !== (t == 8) || dma_ready1 !== 1'b0) begin
        miscompares++;
        $display("FAIL core_read ready t=%0d: got core=%b dma=%b, want core=%b dma=0", t, core_ready1, dma_ready1, t == 8);
      end
      vectors++;
      if (busy1 !== (t >= 6 && t <= 8)) begin
        miscompares++;
        $display("FAIL core_read busy t=%0d: got %b, want %b", t, busy1, (t >= 6 && t <= 8));
      end
      if (core_ready1 || dma_ready1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL core_read pop t=%0d: got a ready, want none", t);
        end else begin
          e = exp_q.pop_front();
          if (core_ready1 !== (e.id == PORT_CORE) || t != e.cyc || core_rdata1 !== e.rdata) begin
            miscompares++;
            $display("FAIL core_read resp: got core=%b t=%0d rdata=%h, want core=%b t=%0d rdata=%h",
                     core_ready1, t, core_rdata1, e.id == PORT_CORE, e.cyc, e.rdata);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL core_read leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic exp_en;
    do_reset();
    for (int t = 1; t <= 17; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h200;
        push_exp(PORT_CORE, 1'b1, mem_val(32'h100), 4);
        push_exp(PORT_DMA,  1'b1, mem_val(32'h200), 8);
        push_exp(PORT_CORE, 1'b1, mem_val(32'h100), 12);
        push_exp(PORT_DMA,  1'b1, mem_val(32'h200), 16);
      end
      if (t == 17) begin core_req = 1'b0; dma_req = 1'b0; end
      @(negedge clk);
      exp_en = (t == 2 || t == 6 || t == 10 || t == 14);
      vectors++;
      if (mem_en1 !== exp_en) begin
        miscompares++;
        $display("FAIL rr mem_en t=%0d: got %b, want %b", t, mem_en1, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if (mem_addr1 !== ((t == 2 || t == 10) ? 32'h100 : 32'h200)) begin
          miscompares++;
          $display("FAIL rr mem_addr t=%0d: got %h, want %h", t, mem_addr1, (t == 2 || t == 10) ? 32'h100 : 32'h200);
        end
      end
      vectors++;
      if (busy1 !== !(t == 1 || t == 5 || t == 9 || t == 13 || t == 17)) begin
        miscompares++;
        $display("FAIL rr busy t=%0d: got %b, want %b", t, busy1, !(t == 1 || t == 5 || t == 9 || t == 13 || t == 17));
      end
      if (core_ready1 || dma_ready1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rr pop t=%0d: got a ready, want none", t);
        end else begin
          e = exp_q.pop_front();
          if ({dma_ready1, core_ready1} !== ((e.id == PORT_DMA) ? 2'b10 : 2'b01) || t != e.cyc ||
              core_rdata1 !== e.rdata || dma_rdata1 !== e.rdata) begin
            miscompares++;
            $display("FAIL rr resp: got dma/core=%b%b t=%0d rdata=%h, want id=%b t=%0d rdata=%h",
                     dma_ready1, core_ready1, t, core_rdata1, e.id, e.cyc, e.rdata);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_dma_write_lat4();
    exp_t e;
    do_reset();
    for (int t = 1; t <= 9; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
        push_exp(PORT_DMA, 1'b0, 32'h0, 7);
      end
      if (t == 8) dma_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_en4 !== (t == 2) || mem_we4 !== (t == 2)) begin
        miscompares++;
        $display("FAIL dma_wr strobes t=%0d: got en=%b we=%b, want %b", t, mem_en4, mem_we4, t == 2);
      end
      if (t >= 2 && t <= 7) begin
        vectors++;
        if (mem_addr4 !== 32'h40 || mem_wdata4 !== 32'h12345678) begin
          miscompares++;
          $display("FAIL dma_wr payload t=%0d: got %h/%h, want 00000040/12345678", t, mem_addr4, mem_wdata4);
        end
      end
      vectors++;
      if (dma_ready4 !== (t == 7) || core_ready4 !== 1'b0) begin
        miscompares++;
        $display("FAIL dma_wr ready t=%0d: got dma=%b core=%b, want dma=%b core=0", t, dma_ready4, core_ready4, t == 7);
      end
      if (core_ready4 || dma_ready4) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL dma_wr pop t=%0d: got a ready, want none", t);
        end else begin
          e = exp_q.pop_front();
          if (dma_ready4 !== (e.id == PORT_DMA) || t != e.cyc) begin
            miscompares++;
            $display("FAIL dma_wr resp: got dma=%b t=%0d, want id=%b t=%0d", dma_ready4, t, e.id, e.cyc);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL dma_wr leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_drop_mid();
    exp_t e;
    do_reset();
    for (int t = 1; t <= 15; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h50;
        push_exp(PORT_CORE, 1'b1, mem_val(32'h30), 7);
        push_exp(PORT_DMA,  1'b1, mem_val(32'h50), 14);
      end
      if (t == 4) core_req = 1'b0;
      if (t == 15) dma_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_en4 !== (t == 2 || t == 9)) begin
        miscompares++;
        $display("FAIL drop mem_en t=%0d: got %b, want %b", t, mem_en4, (t == 2 || t == 9));
      end
      if (t == 9) begin
        vectors++;
        if (mem_addr4 !== 32'h50) begin
          miscompares++;
          $display("FAIL drop dma_addr: got %h, want 00000050", mem_addr4);
        end
      end
      vectors++;
      if (core_ready4 !== (t == 7) || dma_ready4 !== (t == 14)) begin
        miscompares++;
        $display("FAIL drop ready t=%0d: got core=%b dma=%b, want core=%b dma=%b", t, core_ready4, dma_ready4, t == 7, t == 14);
      end
      if (core_ready4 || dma_ready4) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL drop pop t=%0d: got a ready, want none", t);
        end else begin
          e = exp_q.pop_front();
          if (dma_ready4 !== (e.id == PORT_DMA) || t != e.cyc || core_rdata4 !== e.rdata) begin
            miscompares++;
            $display("FAIL drop resp: got dma=%b t=%0d rdata=%h, want id=%b t=%0d rdata=%h",
                     dma_ready4, t, core_rdata4, e.id, e.cyc, e.rdata);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drop leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic exp_busy;
    do_reset();
    for (int t = 1; t <= 13; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin core_req = 1'b1; core_we = 1'b0; core_addr = 32'h60; end
      if (t == 4) reset = 1'b1;
      if (t == 5) begin reset = 1'b0; core_req = 1'b0; end
      if (t == 6) begin
        core_req = 1'b1; core_addr = 32'h70;
        dma_req  = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
        push_exp(PORT_CORE, 1'b1, mem_val(32'h70), 12);
      end
      if (t == 13) begin core_req = 1'b0; dma_req = 1'b0; end
      @(negedge clk);
      exp_busy = (t >= 2 && t <= 4) || (t >= 7 && t <= 12);
      vectors++;
      if (busy4 !== exp_busy) begin
        miscompares++;
        $display("FAIL rst_mid busy t=%0d: got %b, want %b", t, busy4, exp_busy);
      end
      vectors++;
      if (mem_en4 !== (t == 2 || t == 7) || mem_we4 !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid mem_en t=%0d: got en=%b we=%b, want en=%b we=0", t, mem_en4, mem_we4, (t == 2 || t == 7));
      end
      if (t == 7) begin
        vectors++;
        if (mem_addr4 !== 32'h70) begin
          miscompares++;
          $display("FAIL rst_mid tie winner addr: got %h, want 00000070", mem_addr4);
        end
      end
      vectors++;
      if (core_ready4 !== (t == 12) || dma_ready4 !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid ready t=%0d: got core=%b dma=%b, want core=%b dma=0", t, core_ready4, dma_ready4, t == 12);
      end
      if (core_ready4 || dma_ready4) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rst_mid pop t=%0d: got a ready, want none", t);
        end else begin
          e = exp_q.pop_front();
          if (core_ready4 !== (e.id == PORT_CORE) || t != e.cyc || core_rdata4 !== e.rdata) begin
            miscompares++;
            $display("FAIL rst_mid resp: got core=%b t=%0d rdata=%h, want id=%b t=%0d rdata=%h",
                     core_ready4, t, core_rdata4, e.id, e.cyc, e.rdata);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_addr_change();
    exp_t e;
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hAAAA5555;
        push_exp(PORT_CORE, 1'b0, 32'h0, 7);
      end
      if (t == 2) begin core_addr = 32'h20; core_wdata = 32'h11111111; core_we = 1'b0; end
      if (t == 8) core_req = 1'b0;
      @(negedge clk);
      if (t >= 2 && t <= 7) begin
        vectors++;
        if (mem_addr4 !== 32'h10 || mem_wdata4 !== 32'hAAAA5555) begin
          miscompares++;
          $display("FAIL addr_chg hold t=%0d: got %h/%h, want 00000010/aaaa5555", t, mem_addr4, mem_wdata4);
        end
      end
      vectors++;
      if (mem_we4 !== (t == 2)) begin
        miscompares++;
        $display("FAIL addr_chg mem_we t=%0d: got %b, want %b", t, mem_we4, t == 2);
      end
      if (core_ready4 || dma_ready4) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL addr_chg pop t=%0d: got a ready, want none", t);
        end else begin
          e = exp_q.pop_front();
          if (core_ready4 !== (e.id == PORT_CORE) || dma_ready4 !== 1'b0 || t != e.cyc) begin
            miscompares++;
            $display("FAIL addr_chg resp: got core=%b dma=%b t=%0d, want id=%b t=%0d", core_ready4, dma_ready4, t, e.id, e.cyc);
          end
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL addr_chg leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_round_robin();
    test_dma_write_lat4();
    test_drop_mid();
    test_reset_mid();
    test_addr_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
